// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Global-history branch predictor. The IU queries it at fetch and shifts
//   its prediction into the speculative global history register (GHR).
//   The ROB trains the 2-bit counter table at commit and restores the GHR
//   on a mispredict. Commit and mispredict counts are kept for statistics.
//
// Ports
//   clk_in                clock
//   rst_in                synchronous active-high reset
//   rdy_in                global enable; all state holds when low
//   iu_to_bp_pc           PC being fetched
//   iu_to_bp_valid        fetched instruction is a conditional branch
//   bp_to_iu_prediction   predicted taken (combinational)
//   bp_to_iu_ghr          GHR snapshot used for this prediction
//   rob_to_bp_rdy         a conditional branch commits this cycle
//   rob_to_bp_pc          PC of the committing branch
//   rob_to_bp_branch      actual outcome (1 = taken)
//   rob_to_bp_ghr         GHR snapshot that travelled with the branch
//   rob_to_bp_mispredict  committed prediction was wrong
//   bp_commit_cnt         committed branch count
//   bp_mispredict_cnt     mispredicted committed branch count
module gshare_branch_predictor #(
  parameter int unsigned BHT_WIDTH  = 8,
  parameter int unsigned GHR_WIDTH  = 8,
  parameter logic [1:0]  INIT_STATE = 2'b10
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [31:0]          iu_to_bp_pc,
  input  logic                 iu_to_bp_valid,
  output logic                 bp_to_iu_prediction,
  output logic [GHR_WIDTH-1:0] bp_to_iu_ghr,
  input  logic                 rob_to_bp_rdy,
  input  logic [31:0]          rob_to_bp_pc,
  input  logic                 rob_to_bp_branch,
  input  logic [GHR_WIDTH-1:0] rob_to_bp_ghr,
  input  logic                 rob_to_bp_mispredict,
  output logic [31:0]          bp_commit_cnt,
  output logic [31:0]          bp_mispredict_cnt
);

  localparam int unsigned BHT_ENTRIES = 1 << BHT_WIDTH;
  localparam int unsigned PC_IDX_LSB  = 2;
  localparam int unsigned PC_IDX_MSB  = BHT_WIDTH + 1;

  // Illegal history width stops elaboration
  if (GHR_WIDTH < 1 || GHR_WIDTH > BHT_WIDTH) begin : g_cfg_error
    $error("gshare_branch_predictor: GHR_WIDTH must be in 1..BHT_WIDTH");
  end

  logic [1:0]           r_bht [BHT_ENTRIES];
  logic [GHR_WIDTH-1:0] r_ghr;
  logic [31:0]          r_commit_cnt;
  logic [31:0]          r_mispredict_cnt;

  logic [BHT_WIDTH-1:0] w_rd_idx;
  logic [BHT_WIDTH-1:0] w_wr_idx;
  logic                 w_prediction;
  logic                 w_train;
  logic                 w_repair;
  logic                 w_spec;
  logic [1:0]           w_ctr_cur;
  logic [1:0]           w_ctr_next;
  logic [GHR_WIDTH-1:0] w_ghr_spec;
  logic [GHR_WIDTH-1:0] w_ghr_repair;
  logic [GHR_WIDTH-1:0] w_ghr_next;

  // PC bits outside the index field do not affect prediction
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{iu_to_bp_pc[31:PC_IDX_MSB+1], iu_to_bp_pc[PC_IDX_LSB-1:0],
                              rob_to_bp_pc[31:PC_IDX_MSB+1], rob_to_bp_pc[PC_IDX_LSB-1:0]};

  // gshare index: word-aligned PC bits XOR zero-extended history
  assign w_rd_idx = iu_to_bp_pc[PC_IDX_MSB:PC_IDX_LSB] ^ BHT_WIDTH'(r_ghr);
  assign w_wr_idx = rob_to_bp_pc[PC_IDX_MSB:PC_IDX_LSB] ^ BHT_WIDTH'(rob_to_bp_ghr);

  // Query path reads the pre-update table and GHR
  assign w_prediction        = r_bht[w_rd_idx][1];
  assign bp_to_iu_prediction = w_prediction;
  assign bp_to_iu_ghr        = r_ghr;
  assign bp_commit_cnt       = r_commit_cnt;
  assign bp_mispredict_cnt   = r_mispredict_cnt;

  // Event qualification; a mispredict only counts alongside a commit
  assign w_train  = rdy_in & rob_to_bp_rdy;
  assign w_repair = w_train & rob_to_bp_mispredict;
  assign w_spec   = rdy_in & iu_to_bp_valid;

  // Saturating 2-bit counter step toward the actual outcome
  assign w_ctr_cur = r_bht[w_wr_idx];
  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (rob_to_bp_branch) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  // History shift: a 1-bit GHR simply takes the newest outcome
  if (GHR_WIDTH == 1) begin : g_ghr_one
    assign w_ghr_spec   = w_prediction;
    assign w_ghr_repair = rob_to_bp_branch;
  end else begin : g_ghr_shift
    assign w_ghr_spec   = {r_ghr[GHR_WIDTH-2:0], w_prediction};
    assign w_ghr_repair = {rob_to_bp_ghr[GHR_WIDTH-2:0], rob_to_bp_branch};
  end

  // Repair wins over speculation because the IU is being flushed
  always_comb begin
    w_ghr_next = r_ghr;
    if (w_repair) begin
      w_ghr_next = w_ghr_repair;
    end else if (w_spec) begin
      w_ghr_next = w_ghr_spec;
    end
  end

  // Counter table
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        r_bht[i] <= INIT_STATE;
      end
    end else if (w_train) begin
      r_bht[w_wr_idx] <= w_ctr_next;
    end
  end

  // Global history register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ghr <= '0;
    end else if (rdy_in) begin
      r_ghr <= w_ghr_next;
    end
  end

  // Statistics counters, wrapping naturally at 2**32
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_commit_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_train)  r_commit_cnt     <= r_commit_cnt + 32'd1;
      if (w_repair) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Testbench for gshare_branch_predictor: directed scenarios plus random
// traffic, checked against an integer-array reference model.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] iu_pc;
  logic        iu_valid;
  logic        pred;
  logic [7:0]  bp_ghr;
  logic        rob_rdy;
  logic [31:0] rob_pc;
  logic        rob_branch;
  logic [7:0]  rob_ghr;
  logic        rob_mis;
  logic [31:0] ccnt;
  logic [31:0] mcnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_bht [256];
  int          m_ghr;
  logic [31:0] m_commit;
  logic [31:0] m_mis;

  always #5 clk = ~clk;

  gshare_branch_predictor dut (
    .clk_in               (clk),
    .rst_in               (rst),
    .rdy_in               (rdy),
    .iu_to_bp_pc          (iu_pc),
    .iu_to_bp_valid       (iu_valid),
    .bp_to_iu_prediction  (pred),
    .bp_to_iu_ghr         (bp_ghr),
    .rob_to_bp_rdy        (rob_rdy),
    .rob_to_bp_pc         (rob_pc),
    .rob_to_bp_branch     (rob_branch),
    .rob_to_bp_ghr        (rob_ghr),
    .rob_to_bp_mispredict (rob_mis),
    .bp_commit_cnt        (ccnt),
    .bp_mispredict_cnt    (mcnt)
  );

  function automatic int m_idx(input logic [31:0] pc, input int h);
    return int'((pc >> 2) & 32'hFF) ^ (h & 255);
  endfunction

  function automatic logic m_pred(input logic [31:0] pc);
    return m_bht[m_idx(pc, m_ghr)] >= 2;
  endfunction

  // Model one clock edge from the inputs currently applied
  task automatic model_edge();
    logic p;
    int   k;
    if (rst) begin
      for (int i = 0; i < 256; i++) m_bht[i] = 2;
      m_ghr = 0; m_commit = 0; m_mis = 0;
    end else if (rdy) begin
      p = m_pred(iu_pc);
      if (rob_rdy) begin
        k = m_idx(rob_pc, int'(rob_ghr));
        m_bht[k] = rob_branch ? ((m_bht[k] == 3) ? 3 : m_bht[k] + 1)
                              : ((m_bht[k] == 0) ? 0 : m_bht[k] - 1);
        m_commit = m_commit + 1;
      end
      if (rob_rdy && rob_mis) begin
        m_ghr = ((int'(rob_ghr) * 2) + int'(rob_branch)) % 256;
        m_mis = m_mis + 1;
      end else if (iu_valid) begin
        m_ghr = ((m_ghr * 2) + int'(p)) % 256;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; iu_pc = 32'h0; iu_valid = 1'b0;
    rob_rdy = 1'b0; rob_pc = 32'h0; rob_branch = 1'b0; rob_ghr = 8'h0; rob_mis = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    iu_pc = 32'h0000_0100; #1;
    total++; if (pred !== 1'b1) begin $display("FAIL reset_pred got=%0b exp=1", pred); bad++; end
    total++; if (bp_ghr !== 8'h00) begin $display("FAIL reset_ghr got=%h exp=00", bp_ghr); bad++; end
    total++; if (ccnt !== 32'd0) begin $display("FAIL reset_commit got=%0d exp=0", ccnt); bad++; end
    total++; if (mcnt !== 32'd0) begin $display("FAIL reset_mis got=%0d exp=0", mcnt); bad++; end
  endtask

  task automatic test_saturation();
    do_reset();
    rob_rdy = 1'b1; rob_pc = 32'h100; rob_ghr = 8'h00; rob_branch = 1'b0;
    tick(); tick();
    rob_rdy = 1'b0; iu_pc = 32'h100; #1;
    total++; if (pred !== 1'b0) begin $display("FAIL sat_pred2 got=%0b exp=0", pred); bad++; end
    rob_rdy = 1'b1; tick();
    rob_rdy = 1'b0; #1;
    total++; if (pred !== 1'b0) begin $display("FAIL sat_pred3 got=%0b exp=0", pred); bad++; end
    total++; if (ccnt !== 32'd3) begin $display("FAIL sat_commit got=%0d exp=3", ccnt); bad++; end
    // One taken from a saturated 00 reaches only 01, still not-taken
    rob_rdy = 1'b1; rob_branch = 1'b1; tick();
    rob_rdy = 1'b0; #1;
    total++; if (pred !== 1'b0) begin $display("FAIL sat_step_up got=%0b exp=0", pred); bad++; end
  endtask

  task automatic test_spec_history();
    do_reset();
    iu_valid = 1'b1; iu_pc = 32'h100;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (pred !== m_pred(iu_pc)) begin $display("FAIL spec_pred c=%0d got=%0b exp=%0b", c, pred, m_pred(iu_pc)); bad++; end
      tick();
    end
    iu_valid = 1'b0; #1;
    total++; if (bp_ghr !== 8'h07) begin $display("FAIL spec_ghr got=%h exp=07", bp_ghr); bad++; end
    // Weaken only entry 0x47 and observe it through the query index
    rob_rdy = 1'b1; rob_pc = 32'h100; rob_ghr = 8'h07; rob_branch = 1'b0;
    #1;
    total++; if (pred !== 1'b1) begin $display("FAIL spec_same_cycle got=%0b exp=1", pred); bad++; end
    tick();
    rob_rdy = 1'b0; #1;
    total++; if (pred !== 1'b0) begin $display("FAIL spec_idx47 got=%0b exp=0", pred); bad++; end
    iu_pc = 32'h104; #1;
    total++; if (pred !== 1'b1) begin $display("FAIL spec_idx46 got=%0b exp=1", pred); bad++; end
  endtask

  task automatic test_repair_priority();
    idle();
    iu_valid = 1'b1; iu_pc = 32'h100;
    rob_rdy = 1'b1; rob_mis = 1'b1; rob_pc = 32'h200; rob_ghr = 8'h81; rob_branch = 1'b0;
    tick();
    idle(); #1;
    total++; if (bp_ghr !== 8'h02) begin $display("FAIL repair_ghr got=%h exp=02", bp_ghr); bad++; end
    total++; if (mcnt !== 32'd1) begin $display("FAIL repair_mis got=%0d exp=1", mcnt); bad++; end
    total++; if (ccnt !== m_commit) begin $display("FAIL repair_commit got=%0d exp=%0d", ccnt, m_commit); bad++; end
    // Mispredict without a commit must be ignored
    rob_mis = 1'b1; rob_ghr = 8'hFF; rob_branch = 1'b1;
    tick();
    idle(); #1;
    total++; if (bp_ghr !== 8'h02) begin $display("FAIL lone_mis_ghr got=%h exp=02", bp_ghr); bad++; end
    total++; if (mcnt !== 32'd1) begin $display("FAIL lone_mis_cnt got=%0d exp=1", mcnt); bad++; end
  endtask

  task automatic test_aliasing();
    do_reset();
    rob_rdy = 1'b1; rob_pc = 32'h100; rob_ghr = 8'h00; rob_branch = 1'b1; tick();
    rob_ghr = 8'h01; rob_branch = 1'b0; tick(); tick();
    idle(); iu_pc = 32'h100; #1;
    total++; if (pred !== 1'b1) begin $display("FAIL alias_h0 got=%0b exp=1", pred); bad++; end
    // Steer the GHR to 1 through a repair on an unrelated PC
    rob_rdy = 1'b1; rob_mis = 1'b1; rob_pc = 32'h300; rob_ghr = 8'h00; rob_branch = 1'b1;
    tick();
    idle(); iu_pc = 32'h100; #1;
    total++; if (bp_ghr !== 8'h01) begin $display("FAIL alias_ghr got=%h exp=01", bp_ghr); bad++; end
    total++; if (pred !== 1'b0) begin $display("FAIL alias_h1 got=%0b exp=0", pred); bad++; end
  endtask

  task automatic rand_inputs(input logic en);
    rdy        = en;
    iu_valid   = 1'($urandom_range(0, 1));
    iu_pc      = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
    rob_rdy    = 1'($urandom_range(0, 1));
    rob_pc     = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2);
    rob_branch = 1'($urandom_range(0, 1));
    rob_ghr    = ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom_range(0, 3));
    rob_mis    = ($urandom_range(0, 3) == 0);
  endtask

  task automatic test_rdy_hold();
    logic [7:0]  s_ghr;
    logic [31:0] s_c, s_m;
    do_reset();
    for (int c = 0; c < 20; c++) begin rand_inputs(1'b1); tick(); end
    s_ghr = 8'(m_ghr); s_c = m_commit; s_m = m_mis;
    for (int c = 0; c < 5; c++) begin
      rand_inputs(1'b0); rob_rdy = 1'b1; iu_valid = 1'b1; #1;
      total++; if (pred !== m_pred(iu_pc)) begin $display("FAIL hold_pred c=%0d got=%0b exp=%0b", c, pred, m_pred(iu_pc)); bad++; end
      tick(); #1;
      total++; if (bp_ghr !== s_ghr || ccnt !== s_c || mcnt !== s_m)
        begin $display("FAIL hold_state c=%0d got=%h/%0d/%0d exp=%h/%0d/%0d", c, bp_ghr, ccnt, mcnt, s_ghr, s_c, s_m); bad++; end
    end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    total++; if (bp_ghr !== 8'h00 || ccnt !== 32'd0 || mcnt !== 32'd0)
      begin $display("FAIL hold_reset got=%h/%0d/%0d exp=00/0/0", bp_ghr, ccnt, mcnt); bad++; end
    for (int p = 0; p < 8; p++) begin
      iu_pc = 32'(p) << 2; #1;
      total++; if (pred !== 1'b1) begin $display("FAIL hold_reset_pred p=%0d got=%0b exp=1", p, pred); bad++; end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_inputs(($urandom_range(0, 7) != 0));
      rst = ($urandom_range(0, 149) == 0);
      #1;
      total++; if (pred !== m_pred(iu_pc)) begin $display("FAIL rnd_pred c=%0d got=%0b exp=%0b", c, pred, m_pred(iu_pc)); bad++; end
      total++; if (bp_ghr !== 8'(m_ghr)) begin $display("FAIL rnd_ghr c=%0d got=%h exp=%h", c, bp_ghr, 8'(m_ghr)); bad++; end
      total++; if (ccnt !== m_commit || mcnt !== m_mis)
        begin $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, ccnt, mcnt, m_commit, m_mis); bad++; end
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_saturation();
    test_spec_history();
    test_repair_priority();
    test_aliasing();
    test_rdy_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
